tbdec_ctrl: RTL and testbench

//  Access sequencer and arbiter in front of decode_tbdec. Shares its write port between
//  two requesters: the core's mtspr path (single 32-bit TBL/TBU/DEC writes) and the debug

---
 rtl/tbdec_ctrl_if.sv | 31 +++
 rtl/tbdec_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_tbdec_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tbdec_ctrl_if.sv
// Request/response bundle between the core/debug requesters, decode_tbdec and tbdec_ctrl.
// The master modport is the requester/timebase side; the slave modport is tbdec_ctrl.
interface tbdec_ctrl_if;
  logic        cpu_req;
  logic [1:0]  cpu_sel;
  logic [31:0] cpu_val;
  logic        cpu_ack;
  logic        dbg_req;
  logic [63:0] dbg_tb;
  logic        dbg_ack;
  logic        write_tbl;
  logic        write_tbu;
  logic        write_dec;
  logic [31:0] write_val;
  logic        dec_trigger;
  logic        dec_irq_en;
  logic        dec_irq_ack;
  logic        dec_irq;

  modport master (
    output cpu_req, cpu_sel, cpu_val, dbg_req, dbg_tb,
    output dec_trigger, dec_irq_en, dec_irq_ack,
    input  cpu_ack, dbg_ack, write_tbl, write_tbu, write_dec, write_val, dec_irq
  );

  modport slave (
    input  cpu_req, cpu_sel, cpu_val, dbg_req, dbg_tb,
    input  dec_trigger, dec_irq_en, dec_irq_ack,
    output cpu_ack, dbg_ack, write_tbl, write_tbu, write_dec, write_val, dec_irq
  );
endinterface

// File: rtl/tbdec_ctrl.sv
// Arbitrates the decode_tbdec write port between core mtspr writes and atomic debug TB loads,
// and latches rising edges of dec_trigger into a maskable decrementer interrupt request.
module tbdec_ctrl (
  input  logic       clk,
  input  logic       reset,
  tbdec_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CPU_WR = 3'd1,
    ST_DBG_L0 = 3'd2,
    ST_DBG_U  = 3'd3,
    ST_DBG_L  = 3'd4
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_DBG = 1'b1;

  // Strobe vector layout: [0]=TBL, [1]=TBU, [2]=DEC
  function automatic logic [2:0] sel_strobes(input logic [1:0] sel);
    logic [2:0] stb;
    case (sel)
      2'd0:    stb = 3'b001;
      2'd1:    stb = 3'b010;
      2'd2:    stb = 3'b100;
      default: stb = 3'b000;
    endcase
    return stb;
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic        grant_cpu_s;
  logic        grant_dbg_s;
  logic        last_grant_r;
  logic [63:0] tb_hold_r;

  logic [2:0]  strobe_s;
  logic [31:0] write_val_s;
  logic        cpu_ack_s;
  logic        dbg_ack_s;
  logic [2:0]  strobe_r;
  logic [31:0] write_val_r;
  logic        cpu_ack_r;
  logic        dbg_ack_r;

  logic        trig_prev_r;
  logic        pending_r;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic with alternating arbitration when both requesters collide in IDLE
  always_comb begin
    state_nxt_s = state_r;
    grant_cpu_s = 1'b0;
    grant_dbg_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.cpu_req && bus.dbg_req) begin
          if (last_grant_r == GRANT_CPU) begin
            grant_dbg_s = 1'b1;
          end else begin
            grant_cpu_s = 1'b1;
          end
        end else if (bus.cpu_req) begin
          grant_cpu_s = 1'b1;
        end else if (bus.dbg_req) begin
          grant_dbg_s = 1'b1;
        end else begin
          grant_cpu_s = 1'b0;
        end
        if (grant_cpu_s) begin
          state_nxt_s = ST_CPU_WR;
        end else if (grant_dbg_s) begin
          state_nxt_s = ST_DBG_L0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CPU_WR: state_nxt_s = ST_IDLE;
      ST_DBG_L0: state_nxt_s = ST_DBG_U;
      ST_DBG_U:  state_nxt_s = ST_DBG_L;
      ST_DBG_L:  state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state they belong to.
  // CPU_WR is only entered straight from a grant, so the live cpu_sel/cpu_val are the granted ones;
  // TBL is zeroed first so a low-word carry cannot ripple into TBU mid-load.
  always_comb begin
    strobe_s    = 3'b000;
    write_val_s = 32'd0;
    cpu_ack_s   = 1'b0;
    dbg_ack_s   = 1'b0;
    case (state_nxt_s)
      ST_CPU_WR: begin
        strobe_s    = sel_strobes(bus.cpu_sel);
        write_val_s = bus.cpu_val;
        cpu_ack_s   = 1'b1;
      end
      ST_DBG_L0: begin
        strobe_s    = 3'b001;
        write_val_s = 32'd0;
      end
      ST_DBG_U: begin
        strobe_s    = 3'b010;
        write_val_s = tb_hold_r[63:32];
      end
      ST_DBG_L: begin
        strobe_s    = 3'b001;
        write_val_s = tb_hold_r[31:0];
        dbg_ack_s   = 1'b1;
      end
      default: begin
        strobe_s    = 3'b000;
        write_val_s = 32'd0;
      end
    endcase
  end

  // Registered strobes, data and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_r    <= 3'b000;
      write_val_r <= 32'd0;
      cpu_ack_r   <= 1'b0;
      dbg_ack_r   <= 1'b0;
    end else begin
      strobe_r    <= strobe_s;
      write_val_r <= write_val_s;
      cpu_ack_r   <= cpu_ack_s;
      dbg_ack_r   <= dbg_ack_s;
    end
  end

  // Grant history and debug TB capture
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_r <= GRANT_CPU;
      tb_hold_r    <= 64'd0;
    end else if (grant_dbg_s) begin
      last_grant_r <= GRANT_DBG;
      tb_hold_r    <= bus.dbg_tb;
    end else if (grant_cpu_s) begin
      last_grant_r <= GRANT_CPU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

  // Decrementer interrupt latch; a new edge wins over a coincident acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_prev_r <= 1'b0;
      pending_r   <= 1'b0;
    end else begin
      trig_prev_r <= bus.dec_trigger;
      if (bus.dec_trigger && !trig_prev_r) begin
        pending_r <= 1'b1;
      end else if (bus.dec_irq_ack) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign bus.write_tbl = strobe_r[0];
  assign bus.write_tbu = strobe_r[1];
  assign bus.write_dec = strobe_r[2];
  assign bus.write_val = write_val_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dbg_ack   = dbg_ack_r;
  assign bus.dec_irq   = pending_r & bus.dec_irq_en;

endmodule

// File: tb/tb_tbdec_ctrl.sv
// Randomised scoreboard bench for tbdec_ctrl: a transaction-level model predicts every
// strobe/ack window and the decrementer interrupt level; a negedge monitor compares.
module tb_tbdec_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  tbdec_ctrl_if bus ();

  tbdec_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cy;
    logic [2:0]  stb;   // [0]=TBL [1]=TBU [2]=DEC
    logic [31:0] val;
    logic        cack;
    logic        dack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;

  // model state: window index, first free window, pending acks, arbitration memory, irq latch
  int c          = 0;
  int free_at    = 0;
  int cpu_ack_at = -1;
  int dbg_ack_at = -1;
  bit last_dbg_m  = 1'b0;
  bit pend_m      = 1'b0;
  bit trig_prev_m = 1'b0;
  bit cpu_hold    = 1'b0;
  bit dbg_hold    = 1'b0;

  logic [2:0] sel_map [4] = '{3'b001, 3'b010, 3'b100, 3'b000};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
  endtask

  task automatic push(input int cy, input logic [2:0] stb, input logic [31:0] val,
                      input logic cack, input logic dack);
    exp_t e;
    e.cy = cy; e.stb = stb; e.val = val; e.cack = cack; e.dack = dack;
    exp_q.push_back(e);
  endtask

  // Predict what the edge closing window c does, given the inputs currently driven
  task automatic model_step();
    exp_t keep[$];
    bit   gc;
    bit   gd;
    if (reset) begin
      foreach (exp_q[i]) if (exp_q[i].cy <= c) keep.push_back(exp_q[i]);
      exp_q       = keep;
      free_at     = c + 1;
      last_dbg_m  = 1'b0;
      cpu_ack_at  = -1;
      dbg_ack_at  = -1;
      pend_m      = 1'b0;
      trig_prev_m = 1'b0;
    end else begin
      if (c >= free_at) begin
        gc = bus.cpu_req;
        gd = bus.dbg_req;
        if (gc && gd) begin
          if (last_dbg_m) gd = 1'b0;
          else gc = 1'b0;
        end
        if (gc) begin
          push(c + 1, sel_map[bus.cpu_sel], bus.cpu_val, 1'b1, 1'b0);
          free_at = c + 2; cpu_ack_at = c + 1; last_dbg_m = 1'b0;
        end else if (gd) begin
          push(c + 1, 3'b001, 32'd0, 1'b0, 1'b0);
          push(c + 2, 3'b010, bus.dbg_tb[63:32], 1'b0, 1'b0);
          push(c + 3, 3'b001, bus.dbg_tb[31:0], 1'b0, 1'b1);
          free_at = c + 4; dbg_ack_at = c + 3; last_dbg_m = 1'b1;
        end
      end
      if (bus.dec_trigger && !trig_prev_m) pend_m = 1'b1;
      else if (bus.dec_irq_ack) pend_m = 1'b0;
      trig_prev_m = bus.dec_trigger;
    end
  endtask

  // Finish the current window (inputs already driven) and move to the next one
  task automatic do_cycle();
    #1;
    if (mon_en) chk("dec_irq", {63'd0, bus.dec_irq}, {63'd0, pend_m & bus.dec_irq_en});
    model_step();
    @(negedge clk);
    #2;
    c = cyc;
    cpu_hold = 1'b0;
    dbg_hold = 1'b0;
    if (bus.cpu_req && c == cpu_ack_at) begin bus.cpu_req = 1'b0; cpu_hold = 1'b1; end
    if (bus.dbg_req && c == dbg_ack_at) begin bus.dbg_req = 1'b0; dbg_hold = 1'b1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40 && (bus.cpu_req || bus.dbg_req); n++) do_cycle();
    chk("requests_drained", {62'd0, bus.cpu_req, bus.dbg_req}, 64'd0);
  endtask

  task automatic cpu_issue(input logic [1:0] sel, input logic [31:0] val);
    for (int n = 0; n < 40 && (bus.cpu_req || cpu_hold); n++) do_cycle();
    bus.cpu_req = 1'b1; bus.cpu_sel = sel; bus.cpu_val = val;
  endtask

  task automatic dbg_issue(input logic [63:0] tb);
    for (int n = 0; n < 40 && (bus.dbg_req || dbg_hold); n++) do_cycle();
    bus.dbg_req = 1'b1; bus.dbg_tb = tb;
  endtask

  // Monitor: pops an expectation whenever the DUT shows a strobe or ack
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        while (exp_q.size() > 0 && exp_q[0].cy < cyc) begin
          chk("missing_output_window", cyc, exp_q[0].cy);
          void'(exp_q.pop_front());
        end
        if (bus.write_tbl || bus.write_tbu || bus.write_dec || bus.cpu_ack || bus.dbg_ack) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {59'd0, bus.write_dec, bus.write_tbu, bus.write_tbl,
                                      bus.cpu_ack, bus.dbg_ack}, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk("latency", cyc, e.cy);
            chk("strobes", {61'd0, bus.write_dec, bus.write_tbu, bus.write_tbl}, {61'd0, e.stb});
            chk("acks", {62'd0, bus.cpu_ack, bus.dbg_ack}, {62'd0, e.cack, e.dack});
            if (e.stb != 3'b000) chk("write_val", {32'd0, bus.write_val}, {32'd0, e.val});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int c0;
    bus.cpu_req = 1'b0; bus.cpu_sel = 2'd0; bus.cpu_val = 32'd0;
    bus.dbg_req = 1'b0; bus.dbg_tb = 64'd0;
    bus.dec_trigger = 1'b0; bus.dec_irq_en = 1'b0; bus.dec_irq_ack = 1'b0;
    @(negedge clk);
    #2;
    c = cyc;
    do_cycle();
    do_cycle();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("reset_state", {27'd0, bus.write_val, bus.write_tbl, bus.write_tbu, bus.write_dec,
                        bus.cpu_ack, bus.dbg_ack}, 64'd0);
    chk("reset_dec_irq", {63'd0, bus.dec_irq}, 64'd0);

    // DEC write, then a debug load whose low word would carry into TBU
    cpu_issue(2'd2, 32'h0000_0100);
    wait_idle();
    dbg_issue(64'h0000_0001_FFFF_FFF0);
    wait_idle();
    do_cycle();

    // Simultaneous requests, several rounds
    for (int r = 0; r < 4; r++) begin
      bus.cpu_req = 1'b1; bus.cpu_sel = 2'($urandom_range(0, 2)); bus.cpu_val = $urandom;
      bus.dbg_req = 1'b1; bus.dbg_tb = {$urandom, $urandom};
      do_cycle();
      wait_idle();
      do_cycle();
    end

    // Reserved selector: ack with no strobe
    cpu_issue(2'd3, 32'hDEAD_BEEF);
    wait_idle();

    // Decrementer interrupt: masked edge, enable, ack, ack coincident with new edge
    cpu_issue(2'd2, 32'd2);
    do_cycle(); do_cycle(); do_cycle();
    bus.dec_trigger = 1'b1; do_cycle();
    do_cycle();
    bus.dec_irq_en = 1'b1; do_cycle();
    bus.dec_irq_ack = 1'b1; do_cycle();
    bus.dec_irq_ack = 1'b0; do_cycle();
    bus.dec_trigger = 1'b0; do_cycle();
    bus.dec_trigger = 1'b1; bus.dec_irq_ack = 1'b1; do_cycle();
    bus.dec_irq_ack = 1'b0; do_cycle();
    do_cycle();

    // Reset while in DBG_U aborts the load
    wait_idle();
    dbg_issue(64'h1234_5678_9ABC_DEF0);
    c0 = c;
    do_cycle();
    do_cycle();
    if (c != c0 + 2) $display("bench window misaligned: %0d vs %0d", c, c0 + 2);
    pulse_reset();
    chk("strobes_after_reset", {59'd0, bus.write_dec, bus.write_tbu, bus.write_tbl,
                                bus.cpu_ack, bus.dbg_ack}, 64'd0);
    cpu_issue(2'd0, 32'hA5A5_0001);
    do_cycle(); do_cycle(); do_cycle();

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      if (!bus.cpu_req && !cpu_hold && $urandom_range(0, 2) == 0) begin
        bus.cpu_req = 1'b1; bus.cpu_sel = 2'($urandom_range(0, 3)); bus.cpu_val = $urandom;
      end
      if (!bus.dbg_req && !dbg_hold && $urandom_range(0, 3) == 0) begin
        bus.dbg_req = 1'b1; bus.dbg_tb = {$urandom, $urandom};
      end
      if ($urandom_range(0, 5) == 0) bus.dec_trigger = ~bus.dec_trigger;
      if ($urandom_range(0, 7) == 0) bus.dec_irq_en = ~bus.dec_irq_en;
      bus.dec_irq_ack = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 149) == 0) pulse_reset();
      else do_cycle();
    end

    bus.dec_irq_ack = 1'b0;
    wait_idle();
    repeat (6) do_cycle();
    chk("scoreboard_empty", exp_q.size(), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
